l1_icache: RTL and testbench

Level-1 instruction cache that answers the fetch stage's per-cycle instruction request. It returns the aligned 32-bit word as two 16-bit short instructions, a ready flag and a fault flag, all in the same cycle as the request. Misses are refilled one line at a time from L2 through a request/ack/response handshake. The block sits between the fetch stage and the L2 cache.

---
 rtl/icache_pkg.sv | 23 ++
 rtl/icache_refill.sv | 100 ++++++++++
 rtl/l1_icache.sv | 146 ++++++++++++++
 tb/tb_l1_icache.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared state encoding and address-split helpers for the L1 instruction cache.
// Widths are passed in so every cache geometry can reuse the same helpers.
package icache_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RECV} icache_state_t;

  localparam int LINE_WORDS_DEF = 4;
  localparam int LINE_BYTES     = LINE_WORDS_DEF * 4;

  // ob = byte-offset bits of a line, ib = index bits
  function automatic logic [31:0] f_offset(input logic [31:0] addr, input int ob);
    return (addr >> 2) & ((32'd1 << (ob - 2)) - 32'd1);
  endfunction

  function automatic logic [31:0] f_index(input logic [31:0] addr, input int ob, input int ib);
    return (addr >> ob) & ((32'd1 << ib) - 32'd1);
  endfunction

  function automatic logic [31:0] f_tag(input logic [31:0] addr, input int ob, input int ib);
    return addr >> (ob + ib);
  endfunction

endpackage

// File: rtl/icache_refill.sv
// Line refill engine: L2 request/ack handshake, beat counter and error accumulation.
// Emits per-beat array writes and a done/err pulse on the last beat; beats may arrive with gaps.
module icache_refill
  import icache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic [31:0]                   i_line_addr,
  input  logic                          i_inv,
  input  logic                          i_l2_ack,
  input  logic                          i_l2_resp,
  input  logic [31:0]                   i_l2_data,
  input  logic                          i_l2_err,
  output icache_state_t                 o_state,
  output logic                          o_l2_req,
  output logic [31:0]                   o_l2_paddr,
  output logic                          o_we,
  output logic [$clog2(SETS)-1:0]       o_wr_idx,
  output logic [$clog2(LINE_WORDS)-1:0] o_wr_word,
  output logic [31:0]                   o_wr_data,
  output logic                          o_done,
  output logic                          o_err,
  output logic                          o_inv_pend
);

  localparam int OB = 2 + $clog2(LINE_WORDS);
  localparam int IW = $clog2(SETS);
  localparam int CW = $clog2(LINE_WORDS);

  icache_state_t r_state;
  logic          r_l2_req;
  logic [31:0]   r_paddr;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          r_inv_pend;
  logic          w_beat;
  logic          w_last;

  assign w_beat = (r_state == RECV) && i_l2_resp;
  assign w_last = w_beat && (r_cnt == CW'(LINE_WORDS - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_l2_req   <= 1'b0;
      r_paddr    <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_inv_pend <= 1'b0;
    end else begin
      if (i_inv && (r_state != IDLE))
        r_inv_pend <= 1'b1;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state  <= REQ;
            r_l2_req <= 1'b1;
            r_paddr  <= i_line_addr;
          end
        end
        REQ: begin
          if (i_l2_ack) begin
            r_state  <= RECV;
            r_l2_req <= 1'b0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
          end
        end
        RECV: begin
          if (w_beat) begin
            r_cnt <= r_cnt + 1'b1;
            r_err <= r_err | i_l2_err;
          end
          // an inv arriving on the last beat is seen directly by the array owner
          if (w_last) begin
            r_state    <= IDLE;
            r_inv_pend <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_state    = r_state;
  assign o_l2_req   = r_l2_req;
  assign o_l2_paddr = r_paddr;
  assign o_we       = w_beat;
  assign o_wr_idx   = IW'(f_index(r_paddr, OB, IW));
  assign o_wr_word  = r_cnt;
  assign o_wr_data  = i_l2_data;
  assign o_done     = w_last;
  assign o_err      = r_err | i_l2_err;
  assign o_inv_pend = r_inv_pend;

endmodule

// File: rtl/l1_icache.sv
// L1 instruction cache: combinational hit/fault path, one-line refill from L2; hit latency 0.
// Fetch stalls with o_ready=0 while a refill runs; ICACHE_STATS_EN adds hit/miss counters.
module l1_icache
  import icache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_inv,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        o_ready,
  output logic [15:0] o_data0,
  output logic [15:0] o_data1,
  output logic        o_page_fault,
  output logic        o_l2_req,
  output logic [31:0] o_l2_paddr,
  input  logic        i_l2_ack,
  input  logic        i_l2_resp,
  input  logic [31:0] i_l2_data,
  input  logic        i_l2_err,
  output logic [31:0] o_hit_cnt,
  output logic [31:0] o_miss_cnt
);

  localparam int OB = 2 + $clog2(LINE_WORDS);
  localparam int IW = $clog2(SETS);
  localparam int CW = $clog2(LINE_WORDS);
  localparam int TW = 32 - OB - IW;

  logic [SETS-1:0] r_valid;
  logic [TW-1:0]   r_tag  [SETS];
  logic [31:0]     r_data [SETS][LINE_WORDS];
  logic            r_flt_vld;
  logic [31:0]     r_flt_line;

  icache_state_t w_state;
  logic [IW-1:0] w_idx;
  logic [CW-1:0] w_off;
  logic [TW-1:0] w_tag;
  logic [31:0]   w_line;
  logic [31:0]   w_word;
  logic          w_idle, w_hit, w_fmatch, w_ready, w_start, w_inv_all;
  logic          w_we, w_done, w_err, w_inv_pend;
  logic [IW-1:0] w_wr_idx;
  logic [CW-1:0] w_wr_word;
  logic [31:0]   w_wr_data;
  logic [31:0]   w_l2_paddr;

  assign w_idx  = IW'(f_index(i_addr, OB, IW));
  assign w_off  = CW'(f_offset(i_addr, OB));
  assign w_tag  = TW'(f_tag(i_addr, OB, IW));
  assign w_line = {i_addr[31:OB], {OB{1'b0}}};
  assign w_word = r_data[w_idx][w_off];
  assign w_idle = (w_state == IDLE);

  assign w_hit    = w_idle && i_req && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_fmatch = w_idle && i_req && r_flt_vld && (r_flt_line == w_line);
  assign w_ready  = i_rst_n && !i_flush && !(w_idle && i_inv) && (w_hit || w_fmatch);
  // a flushed or invalidating cycle carries a stale request, so no refill is started
  assign w_start  = w_idle && i_req && !w_hit && !w_fmatch && !i_flush && !i_inv;
  assign w_inv_all = (w_idle && i_inv) || (w_done && (w_inv_pend || i_inv));

  assign o_ready      = w_ready;
  assign o_page_fault = w_ready && w_fmatch;
  assign o_data0      = (w_ready && !w_fmatch) ? w_word[15:0]  : 16'd0;
  assign o_data1      = (w_ready && !w_fmatch) ? w_word[31:16] : 16'd0;
  assign o_l2_paddr   = w_l2_paddr;

  icache_refill #(.SETS(SETS), .LINE_WORDS(LINE_WORDS)) u_refill (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (w_start),
    .i_line_addr (w_line),
    .i_inv       (i_inv),
    .i_l2_ack    (i_l2_ack),
    .i_l2_resp   (i_l2_resp),
    .i_l2_data   (i_l2_data),
    .i_l2_err    (i_l2_err),
    .o_state     (w_state),
    .o_l2_req    (o_l2_req),
    .o_l2_paddr  (w_l2_paddr),
    .o_we        (w_we),
    .o_wr_idx    (w_wr_idx),
    .o_wr_word   (w_wr_word),
    .o_wr_data   (w_wr_data),
    .o_done      (w_done),
    .o_err       (w_err),
    .o_inv_pend  (w_inv_pend)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_valid <= '0;
    else if (w_inv_all)
      r_valid <= '0;
    else if (w_done)
      r_valid[w_wr_idx] <= !w_err;
  end

  always_ff @(posedge i_clk) begin
    if (w_we)
      r_data[w_wr_idx][w_wr_word] <= w_wr_data;
    if (w_done && !w_err)
      r_tag[w_wr_idx] <= TW'(f_tag(w_l2_paddr, OB, IW));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_flt_vld  <= 1'b0;
      r_flt_line <= '0;
    end else if (w_done && w_err) begin
      r_flt_vld  <= 1'b1;
      r_flt_line <= w_l2_paddr;
    end else if (i_flush) begin
      r_flt_vld  <= 1'b0;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_ready && !w_fmatch)
        r_hit_cnt <= r_hit_cnt + 32'd1;
      if (w_start)
        r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign o_hit_cnt  = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;
`else
  assign o_hit_cnt  = 32'd0;
  assign o_miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_l1_icache.sv
// Scoreboard bench for l1_icache: fetches push expected words, outputs are popped on o_ready.
`timescale 1ns/1ps
module tb_l1_icache;
  import icache_pkg::*;

  localparam int SETS = 64;
  localparam int LW   = LINE_WORDS_DEF;

  logic        i_clk = 1'b0, i_rst_n = 1'b0, i_flush = 1'b0, i_inv = 1'b0, i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_l2_ack = 1'b0, i_l2_resp = 1'b0, i_l2_err = 1'b0;
  logic [31:0] i_l2_data = '0;
  logic        o_ready, o_page_fault, o_l2_req;
  logic [15:0] o_data0, o_data1;
  logic [31:0] o_l2_paddr, o_hit_cnt, o_miss_cnt;

  l1_icache #(.SETS(SETS), .LINE_WORDS(LW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_inv(i_inv),
    .i_req(i_req), .i_addr(i_addr), .o_ready(o_ready), .o_data0(o_data0),
    .o_data1(o_data1), .o_page_fault(o_page_fault), .o_l2_req(o_l2_req),
    .o_l2_paddr(o_l2_paddr), .i_l2_ack(i_l2_ack), .i_l2_resp(i_l2_resp),
    .i_l2_data(i_l2_data), .i_l2_err(i_l2_err), .o_hit_cnt(o_hit_cnt),
    .o_miss_cnt(o_miss_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed { logic flt; logic [31:0] word; } exp_t;
  exp_t        sb_q[$];
  logic [31:0] paddr_q[$];
  int n_cmp = 0, n_bad = 0;
  int m_hits = 0, m_miss = 0;
  int ack_dly = 0, gap = 0, err_beat = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Backing memory: line 0x1000 holds 0x11110000, 0x33332222, ...; other lines are salted.
  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [15:0] w;
    logic [27:0] s;
    w = {14'd0, a[3:2]};
    s = a[31:4] ^ 28'h0000100;
    return {16'((2 * w + 1) * 16'h1111), 16'((2 * w) * 16'h1111)} ^ {s[15:0], s[15:0]};
  endfunction

  function automatic int exp_lat();
    return 1 + (ack_dly + 1) + LW * (gap + 1);
  endfunction

  initial begin : l2_model
    logic [31:0] p;
    forever begin
      @(posedge i_clk); #1;
      if (o_l2_req) begin
        p = o_l2_paddr;
        paddr_q.push_back(p);
        repeat (ack_dly) begin @(posedge i_clk); #1; end
        i_l2_ack = 1'b1;
        @(posedge i_clk); #1;
        i_l2_ack = 1'b0;
        for (int b = 0; b < LW; b++) begin
          repeat (gap) begin @(posedge i_clk); #1; end
          i_l2_resp = 1'b1;
          i_l2_data = exp_word(p + 32'(4 * b));
          i_l2_err  = (b == err_beat);
          @(posedge i_clk); #1;
          i_l2_resp = 1'b0;
          i_l2_err  = 1'b0;
        end
      end
    end
  end

  // Entered and left at posedge+1; lat = cycles from request to o_ready.
  task automatic fetch(input logic [31:0] a, input logic flt, output int lat);
    exp_t e, g;
    e.flt  = flt;
    e.word = flt ? 32'd0 : exp_word(a);
    sb_q.push_back(e);
    i_req = 1'b1; i_addr = a; lat = 0;
    @(negedge i_clk);
    while (!o_ready && lat < 400) begin
      lat++;
      @(negedge i_clk);
    end
    g = sb_q.pop_front();
    if (o_ready) begin
      chk($sformatf("data0@%h", a), {16'd0, o_data0}, {16'd0, g.word[15:0]});
      chk($sformatf("data1@%h", a), {16'd0, o_data1}, {16'd0, g.word[31:16]});
      chk($sformatf("fault@%h", a), {31'd0, o_page_fault}, {31'd0, g.flt});
      if (!flt) m_hits++;
    end else begin
      chk($sformatf("timeout@%h", a), {31'd0, o_ready}, 32'd1);
    end
    @(posedge i_clk); #1;
    i_req = 1'b0;
  endtask

  task automatic pop_paddr(input string tag, input logic [31:0] line);
    logic [31:0] p;
    p = (paddr_q.size() != 0) ? paddr_q.pop_front() : 32'hdead_beef;
    chk(tag, p, line);
  endtask

  task automatic miss_fetch(input logic [31:0] a, input logic flt);
    int lat;
    fetch(a, flt, lat);
    chk($sformatf("miss_lat@%h", a), 32'(lat), 32'(exp_lat()));
    pop_paddr($sformatf("paddr@%h", a), {a[31:4], 4'h0});
    m_miss++;
  endtask

  task automatic hit_fetch(input logic [31:0] a);
    int lat;
    fetch(a, 1'b0, lat);
    chk($sformatf("hit_lat@%h", a), 32'(lat), 32'd0);
    chk($sformatf("no_l2@%h", a), 32'(paddr_q.size()), 32'd0);
  endtask

  task automatic chk_stats(input string tag);
    @(negedge i_clk);
`ifdef ICACHE_STATS_EN
    chk({tag, "_hits"}, o_hit_cnt, 32'(m_hits));
    chk({tag, "_miss"}, o_miss_cnt, 32'(m_miss));
`else
    chk({tag, "_hits"}, o_hit_cnt, 32'd0);
    chk({tag, "_miss"}, o_miss_cnt, 32'd0);
`endif
    @(posedge i_clk); #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int lat;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ready", {31'd0, o_ready}, 32'd0);
    chk("rst_fault", {31'd0, o_page_fault}, 32'd0);
    chk("rst_l2req", {31'd0, o_l2_req}, 32'd0);
    chk("rst_paddr", o_l2_paddr, 32'd0);
    chk("rst_hits", o_hit_cnt, 32'd0);
    chk("rst_miss", o_miss_cnt, 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    // cold miss then same-line hits
    miss_fetch(32'h0000_1000, 1'b0);
    hit_fetch(32'h0000_1004);
    hit_fetch(32'h0000_100C);
    chk_stats("cold");

    // delayed ack and gapped beats
    ack_dly = 2; gap = 2;
    miss_fetch(32'h0000_1100, 1'b0);
    ack_dly = 0; gap = 0;
    hit_fetch(32'h0000_1104);
    hit_fetch(32'h0000_1108);
    hit_fetch(32'h0000_110C);
    chk_stats("gap");

    // conflict eviction on index 0
    miss_fetch(32'h0000_1000 + 32'(SETS * LINE_BYTES), 1'b0);
    hit_fetch(32'h0000_1008 + 32'(SETS * LINE_BYTES));
    miss_fetch(32'h0000_1000, 1'b0);
    hit_fetch(32'h0000_1100);

    // error beat latches a fault for the whole line
    err_beat = 2;
    miss_fetch(32'h0000_2004, 1'b1);
    err_beat = -1;
    fetch(32'h0000_2008, 1'b1, lat);
    chk("fault_lat", 32'(lat), 32'd0);
    chk("fault_no_l2", 32'(paddr_q.size()), 32'd0);
    i_req = 1'b1; i_addr = 32'h0000_1104; i_flush = 1'b1;
    @(negedge i_clk);
    chk("flush_ready", {31'd0, o_ready}, 32'd0);
    @(posedge i_clk); #1;
    i_flush = 1'b0; i_req = 1'b0;
    miss_fetch(32'h0000_2004, 1'b0);
    chk_stats("err");

    // invalidate during RECV: refill completes but the line is dropped, so it re-misses
    fork
      fetch(32'h0000_3000, 1'b0, lat);
      begin
        repeat (3) @(posedge i_clk);
        #1 i_inv = 1'b1;
        @(posedge i_clk); #1;
        i_inv = 1'b0;
      end
    join
    chk("inv_recv_lat", 32'(lat), 32'(2 * exp_lat()));
    pop_paddr("inv_paddr0", 32'h0000_3000);
    pop_paddr("inv_paddr1", 32'h0000_3000);
    m_miss += 2;
    miss_fetch(32'h0000_1104, 1'b0);
    miss_fetch(32'h0000_1004, 1'b0);

    // invalidate in IDLE
    i_req = 1'b1; i_addr = 32'h0000_1004; i_inv = 1'b1;
    @(negedge i_clk);
    chk("inv_idle_ready", {31'd0, o_ready}, 32'd0);
    @(posedge i_clk); #1;
    i_inv = 1'b0; i_req = 1'b0;
    miss_fetch(32'h0000_1008, 1'b0);
    chk_stats("inv");

    // reset in the middle of RECV
    i_req = 1'b1; i_addr = 32'h0000_4000;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b0; i_req = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("midrst_l2req", {31'd0, o_l2_req}, 32'd0);
    chk("midrst_paddr", o_l2_paddr, 32'd0);
    chk("midrst_ready", {31'd0, o_ready}, 32'd0);
    repeat (10) @(posedge i_clk);
    #1;
    pop_paddr("midrst_req", 32'h0000_4000);
    m_hits = 0; m_miss = 0;
    chk_stats("midrst");
    miss_fetch(32'h0000_1008, 1'b0);
    miss_fetch(32'h0000_4004, 1'b0);
    chk_stats("final");
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
